// File: rtl/vigna_core.sv
// vigna_core: multi-cycle, non-pipelined RV32I core with separate valid/ready
// instruction and data buses; one instruction in flight at a time.
module vigna_core #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        resetn,
    output logic        i_valid,
    input  logic        i_ready,
    output logic [31:0] i_addr,
    input  logic [31:0] i_rdata,
    output logic        d_valid,
    input  logic        d_ready,
    output logic [31:0] d_addr,
    input  logic [31:0] d_rdata,
    output logic [31:0] d_wdata,
    output logic [3:0]  d_wstrb,
    output logic [2:0]  dbg_state
);
    typedef enum logic [2:0] {
        FETCH_REQ  = 3'd0,
        FETCH_WAIT = 3'd1,
        EXEC       = 3'd2,
        MEM        = 3'd3,
        WB         = 3'd4
    } state_t;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    state_t      state, state_nx;
    logic [31:0] pc, pc_next, instr, rd_val;
    logic [1:0]  byte_off;
    logic [31:0] rf [1:31];

    // Handshake: a transfer completes on the rising edge where valid and ready
    // are both 1; valid is then low for at least one cycle before the next one.
    assign i_valid   = (state == FETCH_WAIT);
    assign d_valid   = (state == MEM);
    assign i_addr    = pc;
    assign dbg_state = state;

    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] rs1_val, rs2_val;

    assign opcode  = instr[6:0];
    assign rd      = instr[11:7];
    assign funct3  = instr[14:12];
    assign rs1     = instr[19:15];
    assign rs2     = instr[24:20];
    assign imm_i   = {{20{instr[31]}}, instr[31:20]};
    assign imm_s   = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b   = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u   = {instr[31:12], 12'h000};
    assign imm_j   = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
    assign rs1_val = (rs1 == 5'd0) ? 32'h0 : rf[rs1];
    assign rs2_val = (rs2 == 5'd0) ? 32'h0 : rf[rs2];

    logic        is_load, is_store, wb_en, taken;
    logic [31:0] alu_b, alu_out, exec_val, exec_pc, mem_addr, st_data, ld_shift, ld_val;
    logic [4:0]  shamt;
    logic [3:0]  st_strb;
    logic [15:0] ld_half;

    always_comb begin
        is_load  = (opcode == OP_LOAD);
        is_store = (opcode == OP_STORE);
        wb_en    = (opcode == OP_LUI) || (opcode == OP_AUIPC) || (opcode == OP_JAL) ||
                   (opcode == OP_JALR) || is_load || (opcode == OP_IMM) || (opcode == OP_REG);
        alu_b    = (opcode == OP_REG) ? rs2_val : imm_i;
        shamt    = alu_b[4:0];
        case (funct3)
            3'b000:  alu_out = ((opcode == OP_REG) && instr[30]) ? rs1_val - alu_b : rs1_val + alu_b;
            3'b001:  alu_out = rs1_val << shamt;
            3'b010:  alu_out = {31'h0, $signed(rs1_val) < $signed(alu_b)};
            3'b011:  alu_out = {31'h0, rs1_val < alu_b};
            3'b100:  alu_out = rs1_val ^ alu_b;
            3'b101:  alu_out = instr[30] ? $unsigned($signed(rs1_val) >>> shamt) : rs1_val >> shamt;
            3'b110:  alu_out = rs1_val | alu_b;
            default: alu_out = rs1_val & alu_b;
        endcase
        case (funct3)
            3'b000:  taken = (rs1_val == rs2_val);
            3'b001:  taken = (rs1_val != rs2_val);
            3'b100:  taken = ($signed(rs1_val) < $signed(rs2_val));
            3'b101:  taken = ($signed(rs1_val) >= $signed(rs2_val));
            3'b110:  taken = (rs1_val < rs2_val);
            3'b111:  taken = (rs1_val >= rs2_val);
            default: taken = 1'b0;
        endcase
        exec_val = alu_out;
        exec_pc  = pc + 32'd4;
        case (opcode)
            OP_LUI:    exec_val = imm_u;
            OP_AUIPC:  exec_val = pc + imm_u;
            OP_JAL:    begin exec_val = pc + 32'd4; exec_pc = pc + imm_j; end
            OP_JALR:   begin exec_val = pc + 32'd4; exec_pc = (rs1_val + imm_i) & ~32'd1; end
            OP_BRANCH: if (taken) exec_pc = pc + imm_b;
            default:   ;
        endcase
        mem_addr = rs1_val + (is_store ? imm_s : imm_i);
        case (funct3[1:0])
            2'b00:   begin st_data = {4{rs2_val[7:0]}};  st_strb = 4'b0001 << mem_addr[1:0]; end
            2'b01:   begin st_data = {2{rs2_val[15:0]}}; st_strb = mem_addr[1] ? 4'b1100 : 4'b0011; end
            default: begin st_data = rs2_val;            st_strb = 4'b1111; end
        endcase
        ld_shift = d_rdata >> {byte_off, 3'b000};
        ld_half  = byte_off[1] ? d_rdata[31:16] : d_rdata[15:0];
        case (funct3)
            3'b000:  ld_val = {{24{ld_shift[7]}}, ld_shift[7:0]};
            3'b001:  ld_val = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_val = {24'h0, ld_shift[7:0]};
            3'b101:  ld_val = {16'h0, ld_half};
            default: ld_val = d_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) state <= FETCH_REQ;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            FETCH_REQ:  state_nx = FETCH_WAIT;
            FETCH_WAIT: if (i_ready) state_nx = EXEC;
            EXEC:       state_nx = (is_load || is_store) ? MEM : WB;
            MEM:        if (d_ready) state_nx = WB;
            WB:         state_nx = FETCH_REQ;
            default:    state_nx = FETCH_REQ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            pc       <= RESET_ADDR;
            pc_next  <= RESET_ADDR;
            instr    <= 32'h0000_0013;
            rd_val   <= 32'h0;
            byte_off <= 2'b00;
            d_addr   <= 32'h0;
            d_wdata  <= 32'h0;
            d_wstrb  <= 4'h0;
        end else begin
            case (state)
                FETCH_WAIT: if (i_ready) instr <= i_rdata;
                EXEC: begin
                    rd_val  <= exec_val;
                    pc_next <= exec_pc;
                    if (is_load || is_store) begin
                        d_addr   <= {mem_addr[31:2], 2'b00};
                        byte_off <= mem_addr[1:0];
                        d_wdata  <= is_store ? st_data : 32'h0;
                        d_wstrb  <= is_store ? st_strb : 4'h0;
                    end
                end
                MEM: if (d_ready && is_load) rd_val <= ld_val;
                WB:  pc <= pc_next;
                default: ;
            endcase
        end
    end

    // x0 is never stored; reads of it are forced to zero above.
    always_ff @(posedge clk) begin
        if (resetn && (state == WB) && wb_en && (rd != 5'd0))
            rf[rd] <= rd_val;
    end
endmodule

// File: tb/tb_vigna_core.sv
// Directed bench for vigna_core: programs run from a bench memory with
// configurable ready latency; results are checked against hand-computed values.
module tb_vigna_core;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        i_valid, i_ready = 1'b0;
    logic [31:0] i_addr, i_rdata = 32'h0;
    logic        d_valid, d_ready = 1'b0;
    logic [31:0] d_addr, d_rdata = 32'h0, d_wdata;
    logic [3:0]  d_wstrb;
    logic [2:0]  dbg_state;

    vigna_core #(.RESET_ADDR(32'h0)) dut (
        .clk(clk), .resetn(resetn),
        .i_valid(i_valid), .i_ready(i_ready), .i_addr(i_addr), .i_rdata(i_rdata),
        .d_valid(d_valid), .d_ready(d_ready), .d_addr(d_addr), .d_rdata(d_rdata),
        .d_wdata(d_wdata), .d_wstrb(d_wstrb), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111, JALR = 7'b1100111;
    localparam logic [6:0] OPI = 7'b0010011, LOAD = 7'b0000011;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0] imem [64];
    logic [31:0] dmem [64];
    logic [31:0] log_addr[$], log_data[$];
    logic [3:0]  log_strb[$];
    logic [31:0] exp_q[$];
    int lat = 1, i_cnt = 0, d_cnt = 0;
    int checks = 0, failures = 0;

    // Memory responders: ready rises lat cycles after valid, drops once valid does.
    always @(negedge clk) begin
        if (!resetn) begin
            i_ready = 1'b0; d_ready = 1'b0; i_cnt = 0; d_cnt = 0;
        end else begin
            if (i_valid && !i_ready) begin
                if (i_cnt + 1 >= lat) begin
                    i_ready = 1'b1; i_rdata = imem[i_addr[7:2]]; i_cnt = 0;
                end else i_cnt++;
            end else i_ready = 1'b0;
            if (d_valid && !d_ready) begin
                if (d_cnt + 1 >= lat) begin
                    d_ready = 1'b1; d_cnt = 0;
                    if (d_wstrb != 4'h0) begin
                        for (int b = 0; b < 4; b++)
                            if (d_wstrb[b]) dmem[d_addr[7:2]][8*b +: 8] = d_wdata[8*b +: 8];
                        log_addr.push_back(d_addr); log_data.push_back(d_wdata); log_strb.push_back(d_wstrb);
                    end else d_rdata = dmem[d_addr[7:2]];
                end else d_cnt++;
            end else d_ready = 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3, input int rd, input logic [6:0] op);
        return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op};
    endfunction
    function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1, input int f3);
        return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1, input int f3);
        return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] enc_u(input int imm20, input int rd, input logic [6:0] op);
        return {imm20[19:0], rd[4:0], op};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
            $error("check %s observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic check_words(input string tag, input int first);
        int idx = first;
        while (exp_q.size() > 0) begin
            check($sformatf("%s_w%0d", tag, idx), dmem[idx], exp_q.pop_front());
            idx++;
        end
    endtask

    task automatic hold_reset(input int latency);
        resetn = 1'b0;
        lat = latency;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 64; k++) begin imem[k] = NOP; dmem[k] = 32'h0; end
        log_addr.delete(); log_data.delete(); log_strb.delete();
    endtask

    task automatic wait_fetch_addr(input logic [31:0] target, input int max_cycles, output logic [31:0] found);
        found = 32'd0;
        for (int c = 0; c < max_cycles && found == 32'd0; c++) begin
            @(negedge clk); #1;
            if (i_valid && i_ready && i_addr == target) found = 32'd1;
        end
    endtask

    task automatic next_fetch(input int max_cycles, output logic [31:0] addr);
        logic hit = 1'b0;
        addr = 32'hDEAD_BEEF;
        for (int c = 0; c < max_cycles && !hit; c++) begin
            @(negedge clk); #1;
            if (i_valid && i_ready) begin addr = i_addr; hit = 1'b1; end
        end
    endtask

    task automatic load_shifts();
        imem[0] = enc_i(16, 0, 0, 1, OPI);
        imem[1] = enc_i(2, 1, 1, 2, OPI);
        imem[2] = enc_i(2, 1, 5, 3, OPI);
        imem[3] = enc_i(-16, 0, 0, 4, OPI);
        imem[4] = enc_i(32'h402, 4, 5, 5, OPI);
        imem[5] = enc_s(0, 2, 0, 2);
        imem[6] = enc_s(4, 3, 0, 2);
        imem[7] = enc_s(8, 5, 0, 2);
        imem[8] = enc_i(-4, 0, 0, 0, JALR);
    endtask

    logic [31:0] ok, fa;

    initial begin
        // Reset state
        hold_reset(1);
        check("rst_i_valid", {31'h0, i_valid}, 32'h0);
        check("rst_d_valid", {31'h0, d_valid}, 32'h0);
        check("rst_d_wstrb", {28'h0, d_wstrb}, 32'h0);
        check("rst_d_addr", d_addr, 32'h0);
        check("rst_d_wdata", d_wdata, 32'h0);
        check("rst_state", {29'h0, dbg_state}, 32'h0);

        // Shifts, then halt loop wraps PC through 0xFFFFFFFC to 0
        load_shifts();
        resetn = 1'b1;
        wait_fetch_addr(32'hFFFF_FFFC, 150, ok);
        check("shift_halt_fetch", ok, 32'd1);
        exp_q.push_back(32'd64); exp_q.push_back(32'd4); exp_q.push_back(32'hFFFF_FFFC);
        check_words("shift", 0);
        next_fetch(50, fa);
        check("wrap_fetch_addr", fa, 32'h0);

        // Upper immediates; x3 cleared so the branch test can observe it untouched
        hold_reset(1);
        imem[0] = enc_u(32'h12345, 1, LUI);
        imem[1] = enc_i(32'h678, 1, 0, 1, OPI);
        imem[2] = enc_u(32'h01000, 2, AUIPC);
        imem[3] = enc_s(0, 1, 0, 2);
        imem[4] = enc_s(4, 2, 0, 2);
        imem[5] = enc_i(0, 0, 0, 3, OPI);
        imem[6] = enc_i(-4, 0, 0, 0, JALR);
        resetn = 1'b1;
        wait_fetch_addr(32'hFFFF_FFFC, 120, ok);
        check("upper_halt_fetch", ok, 32'd1);
        exp_q.push_back(32'h1234_5678); exp_q.push_back(32'h0100_0008);
        check_words("upper", 0);

        // Taken branch skips the write of x3
        hold_reset(1);
        imem[0] = enc_i(10, 0, 0, 1, OPI);
        imem[1] = enc_i(10, 0, 0, 2, OPI);
        imem[2] = enc_b(8, 2, 1, 0);
        imem[3] = enc_i(99, 0, 0, 3, OPI);
        imem[4] = enc_i(1, 0, 0, 5, OPI);
        imem[5] = enc_s(0, 5, 0, 2);
        imem[6] = enc_s(4, 3, 0, 2);
        imem[7] = enc_i(-4, 0, 0, 0, JALR);
        resetn = 1'b1;
        wait_fetch_addr(32'hFFFF_FFFC, 150, ok);
        check("branch_halt_fetch", ok, 32'd1);
        exp_q.push_back(32'd1); exp_q.push_back(32'd0);
        check_words("branch", 0);

        // Sub-word stores and loads
        hold_reset(1);
        imem[0] = enc_i(32'hAB, 0, 0, 1, OPI);
        imem[1] = enc_s(5, 1, 0, 0);
        imem[2] = enc_i(32'h80, 0, 0, 2, OPI);
        imem[3] = enc_s(5, 2, 0, 0);
        imem[4] = enc_i(5, 0, 0, 3, LOAD);
        imem[5] = enc_i(5, 0, 4, 4, LOAD);
        imem[6] = enc_s(8, 3, 0, 2);
        imem[7] = enc_s(12, 4, 0, 2);
        imem[8] = enc_s(14, 1, 0, 1);
        imem[9] = enc_i(-4, 0, 0, 0, JALR);
        resetn = 1'b1;
        wait_fetch_addr(32'hFFFF_FFFC, 200, ok);
        check("sub_halt_fetch", ok, 32'd1);
        check("sub_store_count", log_addr.size(), 32'd5);
        check("sb_addr", log_addr[0], 32'h4);
        check("sb_wstrb", {28'h0, log_strb[0]}, 32'h2);
        check("sb_wdata", log_data[0], 32'hABAB_ABAB);
        check("sh_wstrb", {28'h0, log_strb[4]}, 32'hC);
        check("sh_wdata", log_data[4], 32'h00AB_00AB);
        exp_q.push_back(32'h0000_8000); exp_q.push_back(32'hFFFF_FF80); exp_q.push_back(32'h00AB_0080);
        check_words("sub", 1);

        // Same shift program with 3-cycle ready latency
        hold_reset(3);
        load_shifts();
        resetn = 1'b1;
        wait_fetch_addr(32'hFFFF_FFFC, 400, ok);
        check("lat3_halt_fetch", ok, 32'd1);
        exp_q.push_back(32'd64); exp_q.push_back(32'd4); exp_q.push_back(32'hFFFF_FFFC);
        check_words("lat3", 0);

        // Reset while a data access is pending
        hold_reset(3);
        load_shifts();
        resetn = 1'b1;
        ok = 32'd0;
        for (int c = 0; c < 200 && ok == 32'd0; c++) begin
            @(negedge clk); #1;
            if (d_valid) ok = 32'd1;
        end
        check("midrst_saw_d_valid", ok, 32'd1);
        resetn = 1'b0;
        @(posedge clk); #1;
        check("midrst_d_valid", {31'h0, d_valid}, 32'h0);
        check("midrst_i_valid", {31'h0, i_valid}, 32'h0);
        check("midrst_d_wstrb", {28'h0, d_wstrb}, 32'h0);
        check("midrst_d_addr", d_addr, 32'h0);
        check("midrst_d_wdata", d_wdata, 32'h0);
        @(negedge clk);
        resetn = 1'b1;
        next_fetch(50, fa);
        check("midrst_restart_addr", fa, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
